jtoutrun_obj_fetch: RTL



---
 rtl/jtoutrun_obj_fetch_if.sv | 26 ++
 rtl/jtoutrun_obj_fetch.sv | 109 ++++++++++
 2 files changed

// File: rtl/jtoutrun_obj_fetch_if.sv
// rtl/jtoutrun_obj_fetch_if.sv - renderer and SDRAM bank-3 signals of the object fetch slot
interface jtoutrun_obj_fetch_if #(
   parameter int AW = 20
);
   logic          obj_cs;
   logic [AW-1:0] obj_addr;
   logic          obj_clr;
   logic [15:0]   obj_data;
   logic          obj_ok;
   logic [21:0]   sdram_addr;
   logic          sdram_req;
   logic          sdram_ack;
   logic          data_dst;
   logic          data_rdy;
   logic [15:0]   data_read;

   modport master (
      output obj_cs, obj_addr, obj_clr, sdram_ack, data_dst, data_rdy, data_read,
      input  obj_data, obj_ok, sdram_addr, sdram_req
   );

   modport slave (
      input  obj_cs, obj_addr, obj_clr, sdram_ack, data_dst, data_rdy, data_read,
      output obj_data, obj_ok, sdram_addr, sdram_req
   );
endinterface

// File: rtl/jtoutrun_obj_fetch.sv
// rtl/jtoutrun_obj_fetch.sv - object ROM SDRAM fetch slot with a small tag cache
// Define JTOUTRUN_OBJ_CACHE_EN for the 2-entry LRU cache; otherwise a single entry.
module jtoutrun_obj_fetch #(
   parameter int          AW     = 20,
   parameter logic [21:0] OFFSET = 22'h0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   jtoutrun_obj_fetch_if.slave  bus
);
`ifdef JTOUTRUN_OBJ_CACHE_EN
   localparam int NE = 2;
`else
   localparam int NE = 1;
`endif

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        r_state;
   logic [NE-1:0] r_valid;
   logic [AW-1:0] r_tag  [NE];
   logic [15:0]   r_data [NE];
   logic [AW-1:0] r_req_addr;
   logic [15:0]   r_last;
   logic [21:0]   r_sdram_addr;
   logic          r_sdram_req;

   logic [NE-1:0] w_hit_vec;
   logic          w_hit;
   logic [15:0]   w_hit_data;
   logic [NE-1:0] w_fill_vec;

`ifdef JTOUTRUN_OBJ_CACHE_EN
   logic          r_lru;
   logic [1:0]    w_valid_eff;

   // Victim is chosen against the post-clear valid bits so clr+rdy lands in entry 0.
   assign w_valid_eff = bus.obj_clr ? 2'b00 : r_valid;
   assign w_fill_vec  = !w_valid_eff[0] ? 2'b01 :
                        !w_valid_eff[1] ? 2'b10 :
                        (r_lru ? 2'b10 : 2'b01);
`else
   assign w_fill_vec  = '1;
`endif

   always_comb begin
      w_hit_vec  = '0;
      w_hit_data = r_last;
      for (int i = 0; i < NE; i++) begin
         w_hit_vec[i] = bus.obj_cs && r_valid[i] && (r_tag[i] == bus.obj_addr);
         if (w_hit_vec[i]) w_hit_data = r_data[i];
      end
   end

   assign w_hit          = |w_hit_vec;
   assign bus.obj_ok     = w_hit;
   assign bus.obj_data   = w_hit_data;
   assign bus.sdram_addr = r_sdram_addr;
   assign bus.sdram_req  = r_sdram_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_req_addr   <= '0;
         r_last       <= '0;
         r_sdram_addr <= OFFSET;
         r_sdram_req  <= 1'b0;
         for (int i = 0; i < NE; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
`ifdef JTOUTRUN_OBJ_CACHE_EN
         r_lru        <= 1'b0;
`endif
      end else begin
         if (bus.obj_clr) r_valid <= '0;
`ifdef JTOUTRUN_OBJ_CACHE_EN
         // r_lru names the least-recent entry; a fill overrides a same-cycle hit.
         if (w_hit) r_lru <= ~w_hit_vec[1];
         if (r_state == WAIT && bus.data_rdy) r_lru <= ~w_fill_vec[1];
`endif
         case (r_state)
            IDLE: if (bus.obj_cs && !w_hit) begin
               r_req_addr   <= bus.obj_addr;
               r_sdram_addr <= OFFSET + 22'(bus.obj_addr);
               r_sdram_req  <= 1'b1;
               r_state      <= REQ;
            end
            REQ: if (bus.sdram_ack) begin
               r_sdram_req <= 1'b0;
               r_state     <= WAIT;
            end
            WAIT: if (bus.data_rdy) begin
               for (int i = 0; i < NE; i++) begin
                  if (w_fill_vec[i]) begin
                     r_valid[i] <= 1'b1;
                     r_tag[i]   <= r_req_addr;
                     r_data[i]  <= bus.data_read;
                  end
               end
               r_last  <= bus.data_read;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
